// File: rtl/cnt_sampler_pkg.sv
// Shared definitions for the counter sampler: FSM states and record field widths.
package cnt_sampler_pkg;

  localparam int unsigned DELTA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  // Channel index width; a single channel still needs one bit on the stream.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Record layout, MSB to LSB: {ch, delta, total}.
  function automatic int unsigned rec_width(input int unsigned n, input int unsigned acc_w);
    return ch_width(n) + DELTA_W + acc_w;
  endfunction

endpackage

// File: rtl/cnt_sampler_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is zero while empty.
module cnt_sampler_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             wr_en, rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en   = push_i && (!full_o || rd_en);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/cnt_sampler.sv
// Periodic snapshot of NUM_CH 8-bit counters: per-channel mod-256 delta and
// saturating running total, streamed out one record per channel per period.
module cnt_sampler
  import cnt_sampler_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PERIOD     = 256,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ACC_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*8-1:0]         cnt_in,
  input  logic                        start,
  input  logic                        stop,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [ch_width(NUM_CH)-1:0] m_ch,
  output logic [DELTA_W-1:0]          m_delta,
  output logic [ACC_W-1:0]            m_total,
  output logic                        overflow,
  output logic                        busy,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned CH_W  = ch_width(NUM_CH);
  localparam int unsigned REC_W = rec_width(NUM_CH, ACC_W);
  localparam int unsigned TMR_W = $clog2(PERIOD);

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q;
  logic [CH_W-1:0]     ch_q;
  logic                stop_seen_q;
  logic [DELTA_W-1:0]  prev_q  [NUM_CH];
  logic [ACC_W-1:0]    total_q [NUM_CH];
  logic                overflow_q;
  logic [7:0]          drop_q;

  logic [DELTA_W-1:0]  cnt_a [NUM_CH];
  logic [DELTA_W-1:0]  delta;
  logic [ACC_W:0]      sum;
  logic                clip;
  logic [ACC_W-1:0]    new_total;
  logic                last_ch, period_end, scan, pop, full, empty;
  logic [REC_W-1:0]    rec_in, rec_out;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_split
    assign cnt_a[g] = cnt_in[8*g +: 8];
  end

  assign scan       = (state_q == ST_SCAN);
  assign last_ch    = (ch_q == CH_W'(NUM_CH - 1));
  assign period_end = (timer_q == TMR_W'(PERIOD - 1));
  assign delta      = cnt_a[ch_q] - prev_q[ch_q];
  assign sum        = {1'b0, total_q[ch_q]} + (ACC_W+1)'(delta);
  assign clip       = sum[ACC_W];
  assign new_total  = clip ? '1 : sum[ACC_W-1:0];
  assign rec_in     = {ch_q, delta, new_total};
  assign pop        = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (stop)            state_d = ST_IDLE;
        else if (period_end) state_d = ST_SCAN;
      end
      ST_SCAN: if (last_ch) state_d = (stop_seen_q || stop) ? ST_IDLE : ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      ch_q        <= '0;
      stop_seen_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        prev_q[i]  <= '0;
        total_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      // Timer free-runs through SCAN so snapshot starts stay PERIOD apart.
      if (state_q != ST_IDLE) timer_q <= period_end ? '0 : timer_q + 1'b1;
      case (state_q)
        ST_IDLE: if (start) begin
          timer_q    <= '0;
          overflow_q <= 1'b0;
          drop_q     <= '0;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            prev_q[i]  <= cnt_a[i];
            total_q[i] <= '0;
          end
        end
        ST_WAIT: if (period_end) begin
          ch_q        <= '0;
          stop_seen_q <= 1'b0;
        end
        ST_SCAN: begin
          prev_q[ch_q]  <= cnt_a[ch_q];
          total_q[ch_q] <= new_total;
          if (clip) overflow_q <= 1'b1;
          ch_q        <= ch_q + 1'b1;
          stop_seen_q <= stop_seen_q || stop;
          if (full && !pop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  cnt_sampler_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (scan),
    .din_i   (rec_in),
    .pop_i   (pop),
    .dout_o  (rec_out),
    .full_o  (full),
    .empty_o (empty)
  );

  assign m_valid                   = !empty;
  assign {m_ch, m_delta, m_total}  = rec_out;
  assign overflow                  = overflow_q;
  assign busy                      = (state_q != ST_IDLE);
  assign drop_cnt                  = drop_q;

endmodule

// File: tb/tb_cnt_sampler.sv
// Directed bench for cnt_sampler with NUM_CH=2, PERIOD=8, FIFO_DEPTH=4, ACC_W=8.
module tb_cnt_sampler;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ACC_W  = 8;

  logic                clk = 1'b0;
  logic                rst_n, start, stop, m_ready;
  logic [NUM_CH*8-1:0] cnt_in;
  logic                m_valid, overflow, busy;
  logic [0:0]          m_ch;
  logic [7:0]          m_delta, drop_cnt;
  logic [ACC_W-1:0]    m_total;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] recq [$];

  always #5 clk = ~clk;

  cnt_sampler #(
    .NUM_CH     (NUM_CH),
    .PERIOD     (8),
    .FIFO_DEPTH (4),
    .ACC_W      (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_in   (cnt_in),
    .start    (start),
    .stop     (stop),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_ch     (m_ch),
    .m_delta  (m_delta),
    .m_total  (m_total),
    .overflow (overflow),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  // Transfers complete on the following rising edge; capture mid-cycle.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) recq.push_back({m_ch, m_delta, m_total});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cnt(input logic [7:0] c0, input logic [7:0] c1);
    cnt_in = {c1, c0};
  endtask

  task automatic expect_rec(input string tag, input logic [0:0] ch,
                            input logic [7:0] d, input logic [7:0] t);
    logic [16:0] r;
    int n = 0;
    while (recq.size() == 0 && n < 40) begin
      cyc(1);
      n++;
    end
    if (recq.size() == 0) begin
      check({tag, "_timeout"}, recq.size(), 1);
    end else begin
      r = recq.pop_front();
      check({tag, "_ch"},    r[16],    ch);
      check({tag, "_delta"}, r[15:8],  d);
      check({tag, "_total"}, r[7:0],   t);
    end
  endtask

  task automatic expect_scan(input string tag, input logic [7:0] d0, input logic [7:0] t0,
                             input logic [7:0] d1, input logic [7:0] t1);
    expect_rec({tag, "_c0"}, 1'b0, d0, t0);
    expect_rec({tag, "_c1"}, 1'b1, d1, t1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; m_ready = 1'b1;
    set_cnt(8'd10, 8'd0);
    cyc(2);
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_total", m_total, 0);
    rst_n = 1'b1; start = 1'b0;
    cyc(1);
    check("idle_busy", busy, 0);

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("armed_busy", busy, 1);
    set_cnt(8'd15, 8'd0);
    expect_scan("s1", 8'd5, 8'd5, 8'd0, 8'd0);
    set_cnt(8'd17, 8'd0);
    expect_scan("s2", 8'd2, 8'd7, 8'd0, 8'd0);
    set_cnt(8'd250, 8'd0);
    expect_scan("s3", 8'd233, 8'd240, 8'd0, 8'd0);
    set_cnt(8'd4, 8'd0);
    expect_scan("wrap", 8'd10, 8'd250, 8'd0, 8'd0);
    check("ovf_before", overflow, 0);
    set_cnt(8'd14, 8'd0);
    expect_scan("sat", 8'd10, 8'd255, 8'd0, 8'd0);
    check("ovf_set", overflow, 1);
    expect_scan("sat_hold", 8'd0, 8'd255, 8'd0, 8'd0);
    check("ovf_sticky", overflow, 1);

    // Three periods with the consumer stalled; the third scan overflows the FIFO.
    m_ready = 1'b0;
    set_cnt(8'd20, 8'd1);
    cyc(8);
    set_cnt(8'd23, 8'd3);
    cyc(8);
    set_cnt(8'd30, 8'd6);
    cyc(8);
    check("bp_drop", drop_cnt, 2);
    check("bp_valid", m_valid, 1);
    check("bp_head_ch", m_ch, 0);
    check("bp_head_delta", m_delta, 6);
    check("bp_none_taken", recq.size(), 0);
    m_ready = 1'b1;
    expect_rec("bp1", 1'b0, 8'd6, 8'd255);
    expect_rec("bp2", 1'b1, 8'd1, 8'd1);
    expect_rec("bp3", 1'b0, 8'd3, 8'd255);
    expect_rec("bp4", 1'b1, 8'd2, 8'd3);
    expect_scan("post_drop", 8'd0, 8'd255, 8'd0, 8'd6);

    // Stop lands on the ch0 scan cycle, five cycles after the last record.
    set_cnt(8'd40, 8'd9);
    cyc(5);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    expect_scan("stop", 8'd10, 8'd255, 8'd3, 8'd9);
    check("stop_busy", busy, 0);
    cyc(20);
    check("stop_quiet", recq.size(), 0);
    check("stop_valid", m_valid, 0);

    set_cnt(8'd100, 8'd50);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("rearm_busy", busy, 1);
    check("rearm_ovf", overflow, 0);
    check("rearm_drop", drop_cnt, 0);
    set_cnt(8'd105, 8'd50);
    expect_scan("rearm", 8'd5, 8'd5, 8'd0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
